// File: rtl/dac_extrema_monitor.sv
// Per-channel extrema detector for DAC sample streams: finds MAX/MIN turning
// points with hysteresis, drives a level flag, counts events and flags completion.
module dac_extrema_monitor #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2,
  parameter int HYST     = 4,
  parameter int CNT_W    = 8,
  parameter int TARGET   = 3
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      en_i,
  input  logic                      clear_i,
  input  logic [CHANNELS-1:0]       sample_valid_i,
  input  logic [CHANNELS*WIDTH-1:0] sample_data_i,
  output logic [CHANNELS-1:0]       level_o,
  output logic [CHANNELS-1:0]       max_pulse_o,
  output logic [CHANNELS-1:0]       min_pulse_o,
  output logic [CHANNELS*CNT_W-1:0] max_cnt_o,
  output logic [CHANNELS*CNT_W-1:0] min_cnt_o,
  output logic [CHANNELS-1:0]       done_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_RISING  = 2'd2,
    S_FALLING = 2'd3
  } state_t;

  // One extra bit keeps every hysteresis sum/difference free of wrap-around.
  localparam logic [WIDTH:0]   HYST_X   = (WIDTH+1)'(HYST);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [31:0]      TARGET_U = 32'(TARGET);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d, peak_q, peak_d, trough_q, trough_d;
    logic [CNT_W-1:0] max_cnt_q, max_cnt_d, min_cnt_q, min_cnt_d;
    logic             level_q, level_d, done_q, done_d;
    logic             max_pulse_q, max_pulse_d, min_pulse_q, min_pulse_d;
    logic             accept_s;
    logic [WIDTH-1:0] data_s;
    logic [WIDTH:0]   data_x, ref_x, peak_x, trough_x;

    assign accept_s = en_i & sample_valid_i[k];
    assign data_s   = sample_data_i[k*WIDTH +: WIDTH];
    assign data_x   = {1'b0, data_s};
    assign ref_x    = {1'b0, ref_q};
    assign peak_x   = {1'b0, peak_q};
    assign trough_x = {1'b0, trough_q};

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        state_q     <= S_IDLE;
        ref_q       <= '0;
        peak_q      <= '0;
        trough_q    <= '0;
        max_cnt_q   <= '0;
        min_cnt_q   <= '0;
        level_q     <= 1'b0;
        done_q      <= 1'b0;
        max_pulse_q <= 1'b0;
        min_pulse_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        ref_q       <= ref_d;
        peak_q      <= peak_d;
        trough_q    <= trough_d;
        max_cnt_q   <= max_cnt_d;
        min_cnt_q   <= min_cnt_d;
        level_q     <= level_d;
        done_q      <= done_d;
        max_pulse_q <= max_pulse_d;
        min_pulse_q <= min_pulse_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      peak_d      = peak_q;
      trough_d    = trough_q;
      max_pulse_d = 1'b0;
      min_pulse_d = 1'b0;
      if (accept_s) begin
        case (state_q)
          S_IDLE: begin
            ref_d   = data_s;
            state_d = S_ACQUIRE;
          end
          S_ACQUIRE: begin
            if (data_x >= ref_x + HYST_X) begin
              peak_d  = data_s;
              state_d = S_RISING;
            end else if (data_x + HYST_X <= ref_x) begin
              trough_d = data_s;
              state_d  = S_FALLING;
            end else begin
              state_d = S_ACQUIRE;
            end
          end
          S_RISING: begin
            if (data_x > peak_x) begin
              peak_d = data_s;
            end else if (peak_x - data_x >= HYST_X) begin
              max_pulse_d = 1'b1;
              trough_d    = data_s;
              state_d     = S_FALLING;
            end else begin
              state_d = S_RISING;
            end
          end
          S_FALLING: begin
            if (data_x < trough_x) begin
              trough_d = data_s;
            end else if (data_x - trough_x >= HYST_X) begin
              min_pulse_d = 1'b1;
              peak_d      = data_s;
              state_d     = S_RISING;
            end else begin
              state_d = S_FALLING;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end else begin
        state_d = state_q;
      end
    end

    // Level follows events even under clear; only the counters yield to clear.
    always_comb begin
      if (max_pulse_d) begin
        level_d = 1'b1;
      end else if (min_pulse_d) begin
        level_d = 1'b0;
      end else begin
        level_d = level_q;
      end
      if (clear_i) begin
        max_cnt_d = '0;
        min_cnt_d = '0;
        done_d    = 1'b0;
      end else begin
        max_cnt_d = (max_pulse_d && (max_cnt_q != CNT_MAX)) ? max_cnt_q + CNT_W'(1) : max_cnt_q;
        min_cnt_d = (min_pulse_d && (min_cnt_q != CNT_MAX)) ? min_cnt_q + CNT_W'(1) : min_cnt_q;
        done_d    = done_q | (32'(min_cnt_d) >= TARGET_U);
      end
    end

    assign level_o[k]                    = level_q;
    assign max_pulse_o[k]                = max_pulse_q;
    assign min_pulse_o[k]                = min_pulse_q;
    assign max_cnt_o[k*CNT_W +: CNT_W]   = max_cnt_q;
    assign min_cnt_o[k*CNT_W +: CNT_W]   = min_cnt_q;
    assign done_o[k]                     = done_q;
  end

endmodule
